// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 encodings,
// the FSM state type and the funct3 legality check.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_RESP} lsu_state_e;

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return f3 inside {F3_SB, F3_SH, F3_SW};
    return f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load data alignment: shifts the read word down to the
// addressed byte lane and sign/zero-extends according to funct3.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  logic [31:0] sh;

  always_comb begin
    sh     = rdata_i >> {off_i, 3'b000};
    data_o = sh;
    case (funct3_i)
      F3_LB:   data_o = {{24{sh[7]}}, sh[7:0]};
      F3_LH:   data_o = {{16{sh[15]}}, sh[15:0]};
      F3_LBU:  data_o = {24'h0, sh[7:0]};
      F3_LHU:  data_o = {16'h0, sh[15:0]};
      default: data_o = sh;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one outstanding data-memory access per instruction.
// Define LSU_MISALIGN_TRAP_EN to turn misaligned half/word accesses into error responses.
module lsu
  import lsu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req,
  output logic        o_ready,
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_rd,
  output logic        o_memValid,
  input  logic        i_memReady,
  output logic [31:0] o_memAddr,
  output logic        o_memWe,
  output logic [3:0]  o_memBe,
  output logic [31:0] o_memWdata,
  input  logic        i_memRvalid,
  input  logic [31:0] i_memRdata,
  output logic        o_rspValid,
  output logic        o_rspWrite,
  output logic [4:0]  o_rspRd,
  output logic [31:0] o_rspData,
  output logic        o_rspErr
);

  localparam logic [15:0] TO_LAST = 16'(MEM_TIMEOUT - 1);

  lsu_state_e  state_q, state_d;
  logic        we_q, we_d, err_q, err_d;
  logic [2:0]  f3_q, f3_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, data_q, data_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] acc_addr, ld_data;
  logic        acc_bad, bad_req;

`ifdef LSU_MISALIGN_TRAP_EN
  assign acc_addr = i_addr;
  assign acc_bad  = (i_funct3[1:0] == 2'b01 && i_addr[0]) ||
                    (i_funct3[1:0] == 2'b10 && |i_addr[1:0]);
`else
  // Without trapping, snap the address down to the access size.
  always_comb begin
    acc_addr = i_addr;
    if (i_funct3[1:0] == 2'b01)      acc_addr[0]   = 1'b0;
    else if (i_funct3[1:0] == 2'b10) acc_addr[1:0] = 2'b00;
  end
  assign acc_bad = 1'b0;
`endif

  assign bad_req = !f3_legal(i_we, i_funct3) || acc_bad;

  lsu_load_align u_align (
    .funct3_i (f3_q),
    .off_i    (addr_q[1:0]),
    .rdata_i  (i_memRdata),
    .data_o   (ld_data)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    err_d   = err_q;
    f3_d    = f3_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (i_req) begin
        we_d    = i_we;
        f3_d    = i_funct3;
        addr_d  = acc_addr;
        wdata_d = i_wdata;
        rd_d    = i_rd;
        data_d  = 32'h0;
        cnt_d   = 16'h0;
        err_d   = bad_req;
        state_d = bad_req ? ST_RESP : ST_REQ;
      end
      ST_REQ: if (i_memReady) begin
        cnt_d   = 16'h0;
        state_d = we_q ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        if (i_memRvalid) begin
          data_d  = ld_data;
          state_d = ST_RESP;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 16'h1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= 3'h0;
      rd_q    <= 5'h0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      data_q  <= 32'h0;
      cnt_q   <= 16'h0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      err_q   <= err_d;
      f3_q    <= f3_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  // Bus and response outputs decode only from registered state.
  always_comb begin
    o_memBe    = 4'h0;
    o_memWdata = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        o_memBe    = 4'b0001 << addr_q[1:0];
        o_memWdata = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        o_memBe    = 4'b0011 << {addr_q[1], 1'b0};
        o_memWdata = {2{wdata_q[15:0]}};
      end
      default: o_memBe = 4'b1111;
    endcase
    if (state_q != ST_REQ) o_memBe = 4'h0;
  end

  assign o_ready    = (state_q == ST_IDLE);
  assign o_memValid = (state_q == ST_REQ);
  assign o_memAddr  = {addr_q[31:2], 2'b00};
  assign o_memWe    = (state_q == ST_REQ) && we_q;
  assign o_rspValid = (state_q == ST_RESP);
  assign o_rspWrite = (state_q == ST_RESP) && !we_q && !err_q;
  assign o_rspErr   = (state_q == ST_RESP) && err_q;
  assign o_rspRd    = (state_q == ST_RESP) ? rd_q : 5'h0;
  assign o_rspData  = (state_q == ST_RESP) ? data_q : 32'h0;

endmodule

// File: tb/tb_lsu.sv
// Randomized bench for lsu against a byte-addressed memory reference model.
module tb_lsu;

  localparam int TMO = 8;

  logic        i_clk = 1'b0, i_reset = 1'b0, i_req = 1'b0, i_we = 1'b0;
  logic [2:0]  i_funct3 = '0;
  logic [31:0] i_addr = '0, i_wdata = '0, i_memRdata = '0;
  logic [4:0]  i_rd = '0;
  logic        i_memReady = 1'b0, i_memRvalid = 1'b0;
  logic        o_ready, o_memValid, o_memWe, o_rspValid, o_rspWrite, o_rspErr;
  logic [31:0] o_memAddr, o_memWdata, o_rspData;
  logic [3:0]  o_memBe;
  logic [4:0]  o_rspRd;

  int n_chk = 0, n_err = 0;

  lsu #(.MEM_TIMEOUT(TMO)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_req(i_req), .o_ready(o_ready),
    .i_we(i_we), .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rd(i_rd), .o_memValid(o_memValid), .i_memReady(i_memReady),
    .o_memAddr(o_memAddr), .o_memWe(o_memWe), .o_memBe(o_memBe),
    .o_memWdata(o_memWdata), .i_memRvalid(i_memRvalid), .i_memRdata(i_memRdata),
    .o_rspValid(o_rspValid), .o_rspWrite(o_rspWrite), .o_rspRd(o_rspRd),
    .o_rspData(o_rspData), .o_rspErr(o_rspErr)
  );

  always #5 i_clk = ~i_clk;

  // mem: what the bus has written; refm: what the ISA semantics say
  logic [7:0] mem [int unsigned];
  logic [7:0] refm[int unsigned];

  function automatic logic [7:0] defb(input logic [31:0] a);
    return (a[7:0] * 8'd37) ^ 8'h5A;
  endfunction
  function automatic logic [7:0] memb(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : defb(a);
  endfunction
  function automatic logic [7:0] refb(input logic [31:0] a);
    return refm.exists(a) ? refm[a] : defb(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      mem[a + i]  = w[8*i +: 8];
      refm[a + i] = w[8*i +: 8];
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // vdly < 0 means the memory never returns read data
  task automatic do_op(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd,
                       input int rdly, input int vdly, input string tag);
    int size, lowc, hs, rv, got;
    bit legal, early, seen;
    logic [31:0] ea, exp_v, v, first_addr, first_wd, exp_wd, w;
    logic [3:0]  first_be, exp_be;
    size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
`ifdef LSU_MISALIGN_TRAP_EN
    early = !legal || (addr % size != 0);
    ea    = addr;
`else
    early = !legal;
    ea    = addr & ~(32'(size) - 32'd1);
`endif
    v = 0;
    for (int i = 0; i < size; i++) v |= 32'(refb(ea + i)) << (8 * i);
    case (f3)
      3'd0:    exp_v = 32'($signed(v[7:0]));
      3'd1:    exp_v = 32'($signed(v[15:0]));
      default: exp_v = v;
    endcase
    exp_be = 4'(((1 << size) - 1) << (ea % 4));
    exp_wd = (size == 1) ? {4{wdata[7:0]}} : (size == 2) ? {2{wdata[15:0]}} : wdata;
    chk({tag, ".ready"}, 32'(o_ready), 32'd1);
    i_req = 1'b1; i_we = we; i_funct3 = f3; i_addr = addr; i_wdata = wdata; i_rd = rd;
    step();
    i_req = 1'b0; i_addr = $urandom; i_wdata = $urandom;
    lowc = 0; hs = -1; rv = -1; got = 0; seen = 0;
    first_addr = 0; first_wd = 0; first_be = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (o_rspValid) begin got = cyc; break; end
      if (o_memValid) begin
        if (!seen) begin
          seen = 1; first_addr = o_memAddr; first_be = o_memBe; first_wd = o_memWdata;
          chk({tag, ".addr"}, o_memAddr, ea & ~32'd3);
          chk({tag, ".be"}, 32'(o_memBe), 32'(exp_be));
          chk({tag, ".we"}, 32'(o_memWe), 32'(we));
          if (we) chk({tag, ".wdata"}, o_memWdata, exp_wd);
        end else begin
          chk({tag, ".addr_stable"}, o_memAddr, first_addr);
          chk({tag, ".be_stable"}, 32'(o_memBe), 32'(first_be));
          if (we) chk({tag, ".wd_stable"}, o_memWdata, first_wd);
        end
      end
      i_memReady = o_memValid && (lowc >= rdly);
      if (o_memValid && !i_memReady) lowc++;
      if (o_memValid && i_memReady) begin
        hs = cyc;
        if (o_memWe) begin
          for (int b = 0; b < 4; b++) if (o_memBe[b]) mem[o_memAddr + b] = o_memWdata[8*b +: 8];
        end else if (vdly >= 0) rv = cyc + 1 + vdly;
      end
      i_memRvalid = 1'b0;
      i_memRdata  = $urandom;
      if (cyc == rv) begin
        w = o_memAddr;
        i_memRvalid = 1'b1;
        i_memRdata  = {memb(w + 3), memb(w + 2), memb(w + 1), memb(w)};
      end else if ((hs < 0 || hs == cyc) && ($urandom % 3 == 0)) begin
        i_memRvalid = 1'b1;  // outside WAIT: must be ignored
      end
      step();
    end
    i_memReady = 1'b0; i_memRvalid = 1'b0;
    if (early) chk({tag, ".lat"}, 32'(got), 32'd1);
    else if (we) chk({tag, ".lat"}, 32'(got), 32'(2 + rdly));
    else if (vdly >= 0) chk({tag, ".lat"}, 32'(got), 32'(3 + rdly + vdly));
    else chk({tag, ".lat_tmo"}, 32'(got >= 1 + rdly + TMO && got <= 3 + rdly + TMO), 32'd1);
    if (early) chk({tag, ".nobus"}, 32'(seen), 32'd0);
    chk({tag, ".err"}, 32'(o_rspErr), 32'(early || (!we && vdly < 0)));
    chk({tag, ".write"}, 32'(o_rspWrite), 32'(!early && !we && vdly >= 0));
    chk({tag, ".data"}, o_rspData, (!early && !we && vdly >= 0) ? exp_v : 32'h0);
    if (!early && !we && vdly >= 0) chk({tag, ".rd"}, 32'(o_rspRd), 32'(rd));
    if (!early && we) for (int i = 0; i < size; i++) refm[ea + i] = wdata[8*i +: 8];
    step();
    chk({tag, ".pulse"}, 32'(o_rspValid), 32'd0);
    chk({tag, ".idle"}, 32'(o_ready), 32'd1);
  endtask

  initial begin
    int seen_rsp;
    #1;
    chk("rst.ready", 32'(o_ready), 32'd1);
    chk("rst.memValid", 32'(o_memValid), 32'd0);
    chk("rst.rspValid", 32'(o_rspValid), 32'd0);
    chk("rst.be", 32'(o_memBe), 32'd0);
    chk("rst.rspData", o_rspData, 32'd0);
    chk("rst.memAddr", o_memAddr, 32'd0);
    repeat (2) step();
    i_reset = 1'b1;
    step();

    do_op(1, 3'b000, 32'h1003, 32'h0000_00AB, 5'd0, 0, 0, "sb");
    poke(32'h2000, 32'h0000_8000);
    do_op(0, 3'b000, 32'h2001, 0, 5'd5, 0, 0, "lb");
    do_op(0, 3'b100, 32'h2001, 0, 5'd6, 0, 0, "lbu");
    poke(32'h2000, 32'h8765_4321);
    do_op(0, 3'b001, 32'h2002, 0, 5'd7, 0, 0, "lh");
    do_op(0, 3'b010, 32'h2000, 0, 5'd8, 0, 0, "lw");
    do_op(0, 3'b010, 32'h2002, 0, 5'd9, 0, 0, "lwmis");
    do_op(1, 3'b001, 32'h1001, 32'h1234_BEEF, 5'd0, 2, 0, "shmis");
    do_op(0, 3'b010, 32'h2004, 0, 5'd10, 5, -1, "tmo");
    do_op(0, 3'b011, 32'h2000, 0, 5'd11, 0, 0, "ill_ld");
    do_op(1, 3'b100, 32'h2000, 32'h1, 5'd12, 0, 0, "ill_st");

    // reset while waiting for read data
    i_req = 1'b1; i_we = 1'b0; i_funct3 = 3'b010; i_addr = 32'h2000; i_rd = 5'd13;
    step();
    i_req = 1'b0; i_memReady = 1'b1;
    step();
    i_memReady = 1'b0;
    i_reset = 1'b0;
    #2;
    chk("rstw.ready", 32'(o_ready), 32'd1);
    chk("rstw.memValid", 32'(o_memValid), 32'd0);
    step();
    i_reset = 1'b1; i_memRvalid = 1'b1; i_memRdata = 32'hDEAD_BEEF;
    seen_rsp = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      i_memRvalid = 1'b0;
      if (o_rspValid || !o_ready) seen_rsp++;
    end
    chk("rstw.quiet", 32'(seen_rsp), 32'd0);
    do_op(0, 3'b010, 32'h2000, 0, 5'd14, 1, 2, "post");

    for (int n = 0; n < 60; n++) begin
      bit we;
      logic [2:0] f3;
      we = 1'($urandom);
      f3 = ($urandom % 8 == 0) ? 3'($urandom) :
           (we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5)));
      if (!we && f3 == 3'd3) f3 = 3'd4;
      do_op(we, f3, 32'h3000 + 32'($urandom_range(0, 15)), $urandom, 5'($urandom),
            $urandom_range(0, 3), ($urandom % 10 == 0) ? -1 : $urandom_range(0, 3),
            $sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit in the execute/memory stage, directly downstream of the ALU: it takes the ALU result as the effective address, runs one data-memory transaction per instruction over a valid/ready bus, and returns aligned, sign- or zero-extended load data plus destination register to writeback. Handles RV32I LB/LH/LW/LBU/LHU/SB/SH/SW, one outstanding access at a time.

## Interface
- MEM_TIMEOUT, 255: cycles to wait for read data before an error response; 1..65535.
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_req  in  1  request valid from execute.
- o_ready  out  1  LSU can accept a request.
- i_we  in  1  1 = store, 0 = load.
- i_funct3  in  3  RV32I width/sign field.
- i_addr  in  32  effective address (ALU o_aluData).
- i_wdata  in  32  store data (rs2).
- i_rd  in  5  load destination register.
- o_memValid  out  1  memory request valid.
- i_memReady  in  1  memory accepts request.
- o_memAddr  out  32  word address, bits [1:0] = 0.
- o_memWe  out  1  write strobe.
- o_memBe  out  4  byte enables.
- o_memWdata  out  32  lane-replicated store data.
- i_memRvalid  in  1  read data valid.
- i_memRdata  in  32  read word.
- o_rspValid  out  1  one-cycle completion pulse.
- o_rspWrite  out  1  writeback required (load without error).
- o_rspRd  out  5  destination register.
- o_rspData  out  32  extended load data; 0 for stores/errors.
- o_rspErr  out  1  misaligned, illegal funct3, or timeout.

## Operation
- States: IDLE, REQ, WAIT, RESP. o_ready = (state == IDLE).
- IDLE: on i_req, capture we/funct3/addr/wdata/rd. Illegal funct3 (load 011/110/111, store 011..111) or misalignment (see Configuration) -> RESP with error, no bus access; else -> REQ.
- REQ: o_memValid held with stable address/we/be/wdata until i_memReady. Store -> RESP; load -> WAIT, timeout counter cleared.
- WAIT: on i_memRvalid capture extended data -> RESP. Counter increments each cycle; reaching MEM_TIMEOUT -> RESP with error, o_rspData = 0.
- RESP: o_rspValid = 1 for exactly one cycle -> IDLE.
- Byte enables: byte 4'b0001 << addr[1:0]; half 4'b0011 << {addr[1],1'b0}; word 4'b1111.
- Store data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
- Load: shift i_memRdata right by 8*addr[1:0]; LB/LH sign-extend bit 7/15, LBU/LHU zero-extend, LW unchanged.
- i_memRvalid outside WAIT ignored.

## Timing
- Reset: state IDLE, counter 0, all outputs 0 except o_ready = 1.
- Request accepted at edge T; o_memValid from cycle T+1.
- Store with immediate ready: o_rspValid in T+2; o_ready back in T+3.
- Load with immediate ready and rvalid one cycle later: o_rspValid in T+3; earliest rvalid is the cycle after the ready handshake.
- Error without bus access: o_rspValid in T+1.
- All outputs registered or decoded from registered state only; no combinational path from i_memRdata to o_rspData.
- Reset mid-transaction: immediate return to IDLE; pending read data dropped; no response.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: half at addr[0]=1 or word at addr[1:0]!=0 -> error response, no bus access.
- Undefined: no check; low address bits forced to natural alignment (half clears bit 0, word clears [1:0]) before be/shift computation.

## Structure
- lsu_pkg: funct3 localparams (LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=000, SH=001, SW=010), state enum type.
- Sub-module lsu_load_align: combinational rdata shift and sign/zero extension from funct3 and addr[1:0].

## Test plan
- SB addr 0x1003 wdata 0xAB -> o_memAddr 0x1000, be 4'b1000, wdata 0xABABABAB, rspValid, rspWrite 0.
- LB addr 0x2001, rdata 0x0000_8000 -> o_rspData 0xFFFFFF80; LBU same -> 0x00000080; rd echoed.
- LH addr 0x2002, rdata 0x8765_4321 -> 0xFFFF8765; LW addr 0x2000 -> 0x87654321, rspValid exactly T+3.
- LW addr 0x2002: with LSU_MISALIGN_TRAP_EN -> rspErr in T+1, o_memValid never asserted; without -> access at 0x2000.
- Load with i_memReady low 5 cycles, then no rvalid, MEM_TIMEOUT=8 -> address stable throughout; rspErr, rspData 0, rspWrite 0.
- i_reset low while in WAIT, late rvalid after release -> no o_rspValid, o_ready 1, next request served normally.
